serial_frame_assembler: RTL and testbench
=========================================

// Module: serial_frame_assembler
// PURPOSE
//  Upstream feeder for the 9-bit ones-count/ID-digit detector.
//  Deserializes a 1-bit serial stream into WIDTH-bit frames and computes each frame's
//  popcount incrementally while bits arrive. Presents {m_data, m_ones} to the detector
//  on a valid/ready handshake, with drop-on-overflow and an overflow counter.
// PARAMETERS
//  WIDTH  9                     frame length in bits (drives detector M); legal >= 2
//  CNTW   $clog2(WIDTH+1) (=4)  width of bit-position and ones counters
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous, active-low reset
//  s_valid  in   1      serial bit qualifier; s_bit/s_sof sampled only when high
//  s_bit    in   1      serial data bit; first bit of a frame lands in m_data[WIDTH-1]
//  s_sof    in   1      start-of-frame; with s_valid, restarts framing at this bit
//  m_data   out  WIDTH  assembled frame (feeds detector M)
//  m_ones   out  CNTW   number of 1s in m_data
//  m_valid  out  1      m_data/m_ones hold a frame not yet taken
//  m_ready  in   1      downstream accepts frame when m_valid && m_ready
//  ovf      out  1      1-cycle pulse: completed frame dropped
//  ovf_cnt  out  8      dropped-frame count, saturates at 255
// BEHAVIOUR
//  Reset (async assert, sync release): shift reg, bit_cnt, run_ones, m_data, m_ones,
//   m_valid, ovf, ovf_cnt all 0; state = IDLE.
//  Serial side always accepts bits; no backpressure. Overflow policy is drop-newest.
//  FSM over bit_cnt (bits held in the partial frame):
//   IDLE (bit_cnt==0): s_valid -> shift in s_bit, bit_cnt=1, run_ones=s_bit -> FILL.
//    s_sof is irrelevant in IDLE.
//   FILL: s_valid && s_sof -> discard partial; bit_cnt=1, run_ones=s_bit (new frame).
//    s_valid && !s_sof && bit_cnt<WIDTH-1 -> shift, bit_cnt++, run_ones+=s_bit.
//    s_valid && !s_sof && bit_cnt==WIDTH-1 -> frame COMPLETE this cycle -> IDLE.
//    !s_valid -> hold everything; gaps of any length are legal.
//  Shift: sreg <= {sreg[WIDTH-2:0], s_bit}. First bit received becomes MSB.
//  On COMPLETE: frame = {sreg[WIDTH-2:0], s_bit}; ones = run_ones + s_bit.
//  take = m_valid && m_ready.
//   COMPLETE && (!m_valid || take): load m_data/m_ones on that edge; m_valid=1.
//    Latency: m_valid is high the cycle after the last bit is presented.
//   COMPLETE && m_valid && !m_ready: frame dropped; m_data/m_ones unchanged;
//    ovf=1 for one cycle; ovf_cnt++ (held at 255 once reached).
//   take && !COMPLETE: m_valid=0. m_data/m_ones keep their last value.
//   take && COMPLETE same cycle: new frame loaded; m_valid stays 1; no ovf.
//  While m_valid && !m_ready, m_data/m_ones are stable.
//  s_sof with !s_valid is ignored.
//  Async reset mid-frame discards the partial frame and any held output frame.
//  m_ones is in range 0..WIDTH; it never wraps.
// TESTING
//  T1 m_ready=1; bits 1,0,1,1,0,0,1,1,1, s_sof on first -> next cycle
//     m_data=9'b101100111, m_ones=6, m_valid=1 for exactly 1 cycle.
//  T2 Same bits as T1 with random s_valid gaps -> identical m_data/m_ones.
//     m_valid rises 1 cycle after the 9th valid bit.
//  T3 m_ready=0; frame 9'h0AA, then frame 9'h155 -> m_data stays 9'h0AA,
//     m_ones=4, ovf pulses once, ovf_cnt=1. Then m_ready=1 -> m_valid drops.
//  T4 m_valid=1 (9'h000, m_ones=0); next frame's last bit arrives with m_ready=1 ->
//     m_valid stays 1, m_data=9'h1FF, m_ones=9, ovf=0.
//  T5 Send 4 bits, then s_sof + 9'h1FF -> output 9'h1FF, m_ones=9, no partial leak.
//     Also drive 300 drops -> ovf_cnt saturates at 255.
//  T6 Assert rst_n=0 mid-frame after 5 bits -> all outputs 0 immediately.
//     After release, 9 bits of 9'h003 -> m_data=9'h003, m_ones=2.

Source files
------------

// File: rtl/serial_frame_assembler.sv
// Serial-to-parallel frame assembler: builds WIDTH-bit frames MSB-first from a 1-bit stream,
// tracks the frame popcount on the fly, and hands frames downstream with drop-newest overflow.
module serial_frame_assembler #(
    parameter int WIDTH = 9,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_sof,
    output logic [WIDTH-1:0] m_data,
    output logic [CNTW-1:0]  m_ones,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             ovf,
    output logic [7:0]       ovf_cnt
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CNTW-1:0]  bit_cnt, bit_cnt_nxt;
    logic [CNTW-1:0]  run_ones, run_ones_nxt;
    logic [WIDTH-1:0] frame;
    logic [CNTW-1:0]  frame_ones;
    logic             complete;
    logic             take;

    assign frame      = {sreg[WIDTH-2:0], s_bit};
    assign frame_ones = run_ones + CNTW'(s_bit);
    assign take       = m_valid && m_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        bit_cnt_nxt  = bit_cnt;
        run_ones_nxt = run_ones;
        complete     = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    sreg_nxt     = frame;
                    bit_cnt_nxt  = CNTW'(1);
                    run_ones_nxt = CNTW'(s_bit);
                    state_nxt    = FILL;
                end
            end
            FILL: begin
                if (s_valid) begin
                    sreg_nxt = frame;
                    if (s_sof) begin
                        // Stale bits left in sreg are shifted out before this frame completes.
                        bit_cnt_nxt  = CNTW'(1);
                        run_ones_nxt = CNTW'(s_bit);
                    end else if (bit_cnt == CNTW'(WIDTH - 1)) begin
                        complete     = 1'b1;
                        bit_cnt_nxt  = '0;
                        run_ones_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        bit_cnt_nxt  = bit_cnt + CNTW'(1);
                        run_ones_nxt = frame_ones;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            run_ones <= '0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            run_ones <= run_ones_nxt;
        end
    end

    // Output holding register: a completed frame loads only if the slot is free or emptying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_ones  <= '0;
            m_valid <= 1'b0;
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            ovf <= 1'b0;
            if (complete && (!m_valid || take)) begin
                m_data  <= frame;
                m_ones  <= frame_ones;
                m_valid <= 1'b1;
            end else if (complete) begin
                ovf <= 1'b1;
                if (ovf_cnt != 8'hFF) begin
                    ovf_cnt <= ovf_cnt + 8'd1;
                end
            end else if (take) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_assembler.sv
// Directed bench for serial_frame_assembler: table-driven per-cycle vectors plus
// hand-written sequences for gaps, overflow, resync, saturation and mid-frame reset.
module tb_serial_frame_assembler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid, s_bit, s_sof, m_ready;
    logic [8:0] m_data;
    logic [3:0] m_ones;
    logic       m_valid, ovf;
    logic [7:0] ovf_cnt;

    int checks   = 0;
    int failures = 0;
    int ovf_seen = 0;

    serial_frame_assembler #(.WIDTH(9)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_bit   (s_bit),
        .s_sof   (s_sof),
        .m_data  (m_data),
        .m_ones  (m_ones),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .ovf     (ovf),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, b, sof, rdy;
        logic       ev;
        logic [8:0] ed;
        logic [3:0] eo;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, b, sof, rdy, ev,
                                input logic [8:0] ed, input logic [3:0] eo, input logic eovf);
        vec_t r;
        r.v = v; r.b = b; r.sof = sof; r.rdy = rdy;
        r.ev = ev; r.ed = ed; r.eo = eo; r.eovf = eovf;
        vecs.push_back(r);
    endfunction

    // Drive one cycle of inputs, let the edge happen, and leave time 1 unit past it.
    task automatic step(input logic v, input logic b, input logic sof, input logic rdy);
        s_valid = v; s_bit = b; s_sof = sof; m_ready = rdy;
        @(posedge clk);
        #1;
        if (ovf) ovf_seen++;
    endtask

    task automatic send_frame(input logic [8:0] f, input logic rdy, input logic sof);
        for (int i = 8; i >= 0; i--) step(1'b1, f[i], sof && (i == 8), rdy);
    endtask

    initial begin
        logic [8:0] t1_bits;
        t1_bits = 9'b101100111;

        // T1: back-to-back bits, m_ready high, sof on first bit.
        for (int i = 0; i < 9; i++)
            add(1'b1, t1_bits[8-i], i == 0, 1'b1, i == 8,
                (i == 8) ? 9'h167 : 9'h000, (i == 8) ? 4'd6 : 4'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h167, 4'd6, 1'b0);
        // T4 setup: frame 0x000 held with m_ready low.
        for (int i = 0; i < 9; i++)
            add(1'b1, 1'b0, i == 0, 1'b0, i == 8,
                (i == 8) ? 9'h000 : 9'h167, (i == 8) ? 4'd0 : 4'd6, 1'b0);
        // T4: next frame's last bit coincides with the take.
        for (int i = 0; i < 9; i++)
            add(1'b1, 1'b1, 1'b0, i == 8, 1'b1,
                (i == 8) ? 9'h1FF : 9'h000, (i == 8) ? 4'd9 : 4'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h1FF, 4'd9, 1'b0);

        s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0; m_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_data",  32'(m_data),  32'd0);
        check("reset ovf_cnt", 32'(ovf_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].sof, vecs[i].rdy);
            check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d m_data",  i), 32'(m_data),  32'(vecs[i].ed));
            check($sformatf("vec%0d m_ones",  i), 32'(m_ones),  32'(vecs[i].eo));
            check($sformatf("vec%0d ovf",     i), 32'(ovf),     32'(vecs[i].eovf));
        end

        // T2: same bits with random gaps; noise on s_bit/s_sof while s_valid is low.
        for (int i = 0; i < 9; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            if (i == 8) check("t2 m_valid before last bit", 32'(m_valid), 32'd0);
            step(1'b1, t1_bits[8-i], i == 0, 1'b1);
        end
        check("t2 m_valid", 32'(m_valid), 32'd1);
        check("t2 m_data",  32'(m_data),  32'h167);
        check("t2 m_ones",  32'(m_ones),  32'd6);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2 m_valid drop", 32'(m_valid), 32'd0);

        // T3: hold 0x0AA, drop 0x155.
        ovf_seen = 0;
        send_frame(9'h0AA, 1'b0, 1'b1);
        check("t3 first m_data", 32'(m_data), 32'h0AA);
        check("t3 first m_ones", 32'(m_ones), 32'd4);
        send_frame(9'h155, 1'b0, 1'b1);
        check("t3 ovf pulse",    32'(ovf),     32'd1);
        check("t3 m_data held",  32'(m_data),  32'h0AA);
        check("t3 m_ones held",  32'(m_ones),  32'd4);
        check("t3 ovf_cnt",      32'(ovf_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3 ovf cleared",  32'(ovf),     32'd0);
        check("t3 ovf pulses",   32'(ovf_seen), 32'd1);
        check("t3 m_valid drop", 32'(m_valid), 32'd0);
        check("t3 ovf_cnt kept", 32'(ovf_cnt), 32'd1);

        // T5: partial frame abandoned by sof.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, i == 0, 1'b0);
            if (i == 4) check("t5 no early frame", 32'(m_valid), 32'd0);
        end
        check("t5 m_valid", 32'(m_valid), 32'd1);
        check("t5 m_data",  32'(m_data),  32'h1FF);
        check("t5 m_ones",  32'(m_ones),  32'd9);

        // T5: saturate ovf_cnt with 300 drops (starts at 1).
        for (int k = 0; k < 253; k++) send_frame(9'h000, 1'b0, 1'b0);
        check("t5 ovf_cnt 254", 32'(ovf_cnt), 32'd254);
        for (int k = 0; k < 47; k++) send_frame(9'h000, 1'b0, 1'b0);
        check("t5 ovf_cnt sat",  32'(ovf_cnt), 32'd255);
        check("t5 m_data kept",  32'(m_data),  32'h1FF);

        // T6: reset mid-frame, then a clean frame without sof.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6 rst m_valid", 32'(m_valid), 32'd0);
        check("t6 rst m_data",  32'(m_data),  32'd0);
        check("t6 rst m_ones",  32'(m_ones),  32'd0);
        check("t6 rst ovf_cnt", 32'(ovf_cnt), 32'd0);
        check("t6 rst ovf",     32'(ovf),     32'd0);
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 8; i >= 0; i--) begin
            if (i == 0) check("t6 m_valid before last", 32'(m_valid), 32'd0);
            step(1'b1, (i < 2), 1'b0, 1'b1);
        end
        check("t6 m_valid", 32'(m_valid), 32'd1);
        check("t6 m_data",  32'(m_data),  32'h003);
        check("t6 m_ones",  32'(m_ones),  32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
